conv_load_sched: RTL and testbench



---
 rtl/conv_pkg.sv | 7 +
 rtl/load_chan_ctr.sv | 36 +++
 rtl/conv_load_sched.sv | 55 +++++
 tb/tb_conv_load_sched.sv | 130 +++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type and address-width check for the convolution load sequencer
package conv_pkg;
  typedef enum logic {S_LOAD, S_CONV} state_t;
  function automatic bit addr_fits(int size, int width);
    return (longint'(1) << width) >= longint'(size);
  endfunction
endpackage

// File: rtl/load_chan_ctr.sv
// load_chan_ctr: one load channel (clk/reset, clr_cnt/clr_full, s_valid/s_ready, wr_en/wr_addr, full) counting SIZE words into memory
module load_chan_ctr
  import conv_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_cnt,
  input  logic                  clr_full,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  full
);
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  last;
  if (!addr_fits(SIZE, ADDR_WIDTH)) begin : g_bad_width
    $error("load_chan_ctr: ADDR_WIDTH too small for SIZE");
  end
  assign s_ready = !full;
  assign wr_en   = s_valid & s_ready;
  assign wr_addr = cnt;
  assign last    = cnt == ADDR_WIDTH'(SIZE - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      full <= 1'b0;
    end else begin
      cnt  <= clr_cnt ? '0 : (wr_en && !last) ? cnt + 1'b1 : cnt;
      full <= clr_full ? 1'b0 : (full | (wr_en & last));
    end
  end
endmodule

// File: rtl/conv_load_sched.sv
// conv_load_sched: frame sequencer loading x/f memories via valid/ready, then holding conv_start until conv_done
module conv_load_sched
  import conv_pkg::*;
#(
  parameter int X_MEM_SIZE       = 8,
  parameter int F_MEM_SIZE       = 4,
  parameter int X_MEM_ADDR_WIDTH = 3,
  parameter int F_MEM_ADDR_WIDTH = 2,
  parameter int FRAME_CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid_x,
  output logic                        s_ready_x,
  input  logic                        s_valid_f,
  output logic                        s_ready_f,
  output logic                        wr_en_x,
  output logic [X_MEM_ADDR_WIDTH-1:0] wr_addr_x,
  output logic                        wr_en_f,
  output logic [F_MEM_ADDR_WIDTH-1:0] wr_addr_f,
  input  logic                        conv_done,
  output logic                        conv_start,
  output logic                        busy,
  output logic [FRAME_CNT_WIDTH-1:0]  frames_done
);
  state_t state;
  logic   x_full, f_full, start_load, end_conv;
  assign start_load = state == S_LOAD && x_full && f_full;
  assign end_conv   = state == S_CONV && conv_done;
  load_chan_ctr #(.SIZE(X_MEM_SIZE), .ADDR_WIDTH(X_MEM_ADDR_WIDTH)) u_x (
    .clk(clk), .reset(reset), .clr_cnt(start_load), .clr_full(end_conv),
    .s_valid(s_valid_x), .s_ready(s_ready_x), .wr_en(wr_en_x), .wr_addr(wr_addr_x), .full(x_full)
  );
  load_chan_ctr #(.SIZE(F_MEM_SIZE), .ADDR_WIDTH(F_MEM_ADDR_WIDTH)) u_f (
    .clk(clk), .reset(reset), .clr_cnt(start_load), .clr_full(end_conv),
    .s_valid(s_valid_f), .s_ready(s_ready_f), .wr_en(wr_en_f), .wr_addr(wr_addr_f), .full(f_full)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_LOAD;
      conv_start  <= 1'b0;
      busy        <= 1'b0;
      frames_done <= '0;
    end else if (start_load) begin
      state      <= S_CONV;
      conv_start <= 1'b1;
      busy       <= 1'b1;
    end else if (end_conv) begin
      state       <= S_LOAD;
      conv_start  <= 1'b0;
      busy        <= 1'b0;
      frames_done <= frames_done + 1'b1;
    end
  end
endmodule

// File: tb/tb_conv_load_sched.sv
// tb_conv_load_sched: randomized directed bench with a word-count reference model for conv_load_sched
module tb_conv_load_sched;
  localparam int X = 8;
  localparam int F = 4;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid_x = 1'b0, s_valid_f = 1'b0, conv_done = 1'b0;
  logic        s_ready_x, s_ready_f, wr_en_x, wr_en_f, conv_start, busy;
  logic [2:0]  wr_addr_x;
  logic [1:0]  wr_addr_f;
  logic [15:0] frames_done;
  int          n_chk = 0, n_err = 0;
  int          xa = 0, fa = 0, cyc = 0, last_acc = 0, low_run = 0;
  bit          conv = 0, had_frame = 0, prev_cs = 0;
  logic [15:0] frames = '0;

  conv_load_sched dut (
    .clk(clk), .reset(reset), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .s_valid_f(s_valid_f), .s_ready_f(s_ready_f), .wr_en_x(wr_en_x), .wr_addr_x(wr_addr_x),
    .wr_en_f(wr_en_f), .wr_addr_f(wr_addr_f), .conv_done(conv_done), .conv_start(conv_start),
    .busy(busy), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input bit vx, input bit vf, input bit dn, input bit rs);
    bit both;
    s_valid_x = vx; s_valid_f = vf; conv_done = dn; reset = rs;
    #1;
    chk("ready_x", {31'b0, s_ready_x}, {31'b0, xa < X});
    chk("ready_f", {31'b0, s_ready_f}, {31'b0, fa < F});
    chk("wr_en_x", {31'b0, wr_en_x}, {31'b0, vx && xa < X});
    chk("wr_en_f", {31'b0, wr_en_f}, {31'b0, vf && fa < F});
    if (vx && xa < X) chk("addr_x", {29'b0, wr_addr_x}, xa);
    if (vf && fa < F) chk("addr_f", {30'b0, wr_addr_f}, fa);
    chk("conv_start", {31'b0, conv_start}, {31'b0, conv});
    chk("busy", {31'b0, busy}, {31'b0, conv});
    chk("frames_done", {16'b0, frames_done}, {16'b0, frames});
    if (conv_start && !prev_cs) begin
      chk("start_latency", cyc - last_acc, 2);
      if (had_frame) chk("gap_ge_x", {31'b0, low_run >= X}, 1);
      had_frame = 1;
    end
    low_run = conv_start ? 0 : low_run + 1;
    prev_cs = conv_start;
    @(posedge clk);
    if (rs) begin
      xa = 0; fa = 0; conv = 0; frames = '0; had_frame = 0; low_run = 0;
    end else if (conv) begin
      if (dn) begin conv = 0; frames = frames + 1'b1; xa = 0; fa = 0; end
    end else begin
      both = xa == X && fa == F;
      if (vx && xa < X) begin xa++; last_acc = cyc; end
      if (vf && fa < F) begin fa++; last_acc = cyc; end
      if (both) conv = 1;
    end
    cyc++;
    #1;
  endtask

  task automatic load_until_start(input int px, input int pf);
    for (int i = 0; i < 400 && !conv_start; i++)
      step($urandom_range(99) < px, $urandom_range(99) < pf, $urandom_range(3) == 0, 0);
    chk("start_timeout", {31'b0, conv_start}, 1);
  endtask

  task automatic finish_conv();
    int hold = $urandom_range(1, 5);
    for (int i = 0; i < hold; i++) step($urandom_range(1), $urandom_range(1), 0, 0);
    step($urandom_range(1), $urandom_range(1), 1, 0);
  endtask

  initial begin
    @(posedge clk); #1;
    step(0, 0, 0, 1);
    step(1, 1, 1, 1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 40 && !conv_start; i++) step(1, 1, 0, 0);
    chk("basic_start", {31'b0, conv_start}, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("frames_after_1", {16'b0, frames_done}, 1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 200 && xa < X; i++) step($urandom_range(1), 1, 0, 0);
    load_until_start(100, 100);
    finish_conv();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    load_until_start(60, 60);
    finish_conv();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    chk("simul_full_x", xa, X);
    chk("simul_full_f", fa, F);
    load_until_start(100, 100);
    finish_conv();
    for (int k = 0; k < 3; k++) begin
      load_until_start(30 + $urandom_range(70), 30 + $urandom_range(70));
      finish_conv();
    end
    chk("frames_after_b2b", {16'b0, frames_done}, 7);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 1);
    step(1, 1, 0, 0);
    load_until_start(80, 80);
    step(0, 0, 0, 0);
    step(1, 1, 1, 1);
    chk("reset_conv", {31'b0, conv_start}, 0);
    chk("reset_frames", {16'b0, frames_done}, 0);
    load_until_start(70, 70);
    finish_conv();
    for (int k = 0; k < 4; k++) begin
      load_until_start($urandom_range(20, 100), $urandom_range(20, 100));
      finish_conv();
    end
    step(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
